// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests/grants and
// a bounded tenure that preempts the owner while other masters wait.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] grnt_q, grnt_d;

  logic [3:0] req;
  logic [3:0] others;
  logic [1:0] idx;
  logic [1:0] win_any, win_other;
  logic       found_any, found_other;
  logic       owner_req, preempt;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign others    = req & ~(4'b0001 << owner_q);
  assign owner_req = req[owner_q];

  // Search owner+1, owner+2, owner+3, owner; the "other" search can never
  // select the owner because its bit is masked out.
  always_comb begin
    idx         = '0;
    win_any     = owner_q;
    win_other   = owner_q;
    found_any   = 1'b0;
    found_other = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = owner_q + 2'(k);
      if (!found_any && req[idx]) begin
        win_any   = idx;
        found_any = 1'b1;
      end
      if (!found_other && others[idx]) begin
        win_other   = idx;
        found_other = 1'b1;
      end
    end
  end

  assign preempt = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && owner_req && found_other;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (found_any) begin
          state_d    = GRANTED;
          owner_d    = win_any;
          hold_cnt_d = '0;
        end
      end
      GRANTED: begin
        if (!owner_req || preempt) begin
          if (found_other) begin
            owner_d    = win_other;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    grnt_d = (state_d == GRANTED) ? ~(4'b0001 << owner_d) : 4'hF;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      owner_q    <= 2'd3;
      hold_cnt_q <= '0;
      grnt_q     <= 4'hF;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grnt_q     <= grnt_d;
    end
  end

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign owner    = owner_q;
  assign busy     = (state_q == GRANTED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter: two instances (MAX_HOLD=4
// and MAX_HOLD=0) checked every cycle against a behavioural model.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_;
  logic [3:0] req4, req0;
  wire  [3:0] g4, g0;
  wire  [1:0] own4, own0;
  wire        busy4, busy0;

  bus_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset_(reset_),
    .m0_req_(~req4[0]), .m1_req_(~req4[1]), .m2_req_(~req4[2]), .m3_req_(~req4[3]),
    .m0_grnt_(g4[0]), .m1_grnt_(g4[1]), .m2_grnt_(g4[2]), .m3_grnt_(g4[3]),
    .owner(own4), .busy(busy4)
  );

  bus_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset_(reset_),
    .m0_req_(~req0[0]), .m1_req_(~req0[1]), .m2_req_(~req0[2]), .m3_req_(~req0[3]),
    .m0_grnt_(g0[0]), .m1_grnt_(g0[1]), .m2_grnt_(g0[2]), .m3_grnt_(g0[3]),
    .owner(own0), .busy(busy0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 mirrors dut4, index 1 mirrors dut0.
  int m_gv[2], m_own[2], m_hc[2], m_mh[2];

  function automatic int pick(int cur, logic [3:0] r, bit excl);
    for (int k = 1; k <= 4; k++) begin
      int m;
      m = (cur + k) % 4;
      if (excl && m == cur) continue;
      if (r[m]) return m;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_gv[d] = 0; m_own[d] = 3; m_hc[d] = 0;
    end
  endtask

  task automatic model_step(int d, logic [3:0] r);
    int w;
    if (m_gv[d] == 0) begin
      w = pick(m_own[d], r, 1'b0);
      if (w >= 0) begin m_gv[d] = 1; m_own[d] = w; m_hc[d] = 0; end
    end else if (!r[m_own[d]]) begin
      w = pick(m_own[d], r, 1'b1);
      if (w >= 0) begin m_own[d] = w; m_hc[d] = 0; end
      else m_gv[d] = 0;
    end else begin
      w = pick(m_own[d], r, 1'b1);
      if (m_mh[d] != 0 && m_hc[d] == m_mh[d] - 1 && w >= 0) begin
        m_own[d] = w; m_hc[d] = 0;
      end else if (m_hc[d] < 255) begin
        m_hc[d]++;
      end
    end
  endtask

  task automatic compare_all(string when);
    logic [3:0] eg;
    for (int d = 0; d < 2; d++) begin
      eg = (m_gv[d] != 0) ? ~(4'b0001 << m_own[d]) : 4'hF;
      check($sformatf("%s grant[d%0d]", when, d), (d == 0) ? 32'(g4) : 32'(g0), 32'(eg));
      check($sformatf("%s owner[d%0d]", when, d), (d == 0) ? 32'(own4) : 32'(own0), 32'(m_own[d]));
      check($sformatf("%s busy[d%0d]", when, d), (d == 0) ? 32'(busy4) : 32'(busy0), 32'(m_gv[d]));
    end
    check({when, " hold[d0]"}, 32'(dut4.hold_cnt_q), 32'(m_hc[0]));
    check({when, " hold[d1]"}, 32'(dut0.hold_cnt_q), 32'(m_hc[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0, req4);
    model_step(1, req0);
    compare_all("cyc");
  endtask

  // Called 1 time unit after a rising edge; reset takes effect without a clock.
  task automatic do_reset();
    reset_ = 1'b0;
    req4   = '0;
    req0   = '0;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  int order[$];
  int cnt;
  int bound;
  int cur;

  initial begin
    m_mh[0] = 4;
    m_mh[1] = 0;
    model_reset();
    reset_ = 1'b1;
    req4   = '0;
    req0   = '0;
    #2;
    do_reset();

    // Single request from master 2, then release.
    req4 = 4'b0100; req0 = 4'b0100;
    tick();
    check("single owner", 32'(own4), 32'd2);
    check("single m2_grnt_", 32'(g4[2]), 32'd0);
    req4 = '0; req0 = '0;
    tick();
    check("release busy", 32'(busy4), 32'd0);
    check("release owner kept", 32'(own4), 32'd2);

    // Round robin with 3-cycle tenures.
    do_reset();
    req4 = 4'hF; req0 = 4'hF;
    tick();
    order.push_back(int'(own4));
    for (int t = 0; t < 4; t++) begin
      tick();
      tick();
      cur = int'(own4);
      req4[cur] = 1'b0; req0 = req4;
      tick();
      check("rr no idle gap", 32'(busy4), 32'd1);
      order.push_back(int'(own4));
      req4[cur] = 1'b1; req0 = req4;
    end
    for (int i = 0; i < 5; i++) check($sformatf("rr order[%0d]", i), 32'(order[i]), 32'(i % 4));

    // Preemption after exactly four cycles.
    do_reset();
    req4 = 4'b0010; req0 = req4;
    tick();
    check("pre m1 granted", 32'(g4[1]), 32'd0);
    cnt = 1;
    req4 = 4'b1010; req0 = req4;
    bound = 0;
    while (g4[1] == 1'b0 && bound < 20) begin
      tick();
      if (g4[1] == 1'b0) cnt++;
      bound++;
    end
    check("pre tenure length", 32'(cnt), 32'd4);
    check("pre m3 granted", 32'(g4[3]), 32'd0);
    tick();
    req4 = 4'b0010; req0 = req4;
    tick();
    check("pre m1 regains", 32'(g4[1]), 32'd0);

    // No contention: counter saturates, grant stays.
    do_reset();
    req4 = 4'b0001; req0 = req4;
    for (int i = 0; i < 300; i++) tick();
    check("sat hold", 32'(dut4.hold_cnt_q), 32'd255);
    check("sat m0_grnt_", 32'(g4[0]), 32'd0);

    // Preemption disabled on the MAX_HOLD=0 instance.
    do_reset();
    req0 = 4'b0011;
    for (int i = 0; i < 100; i++) tick();
    check("nopre owner", 32'(own0), 32'd0);
    req0 = 4'b0010;
    tick();
    check("nopre handover", 32'(g0[1]), 32'd0);

    // Reset mid-tenure, then m0 beats m2.
    do_reset();
    req4 = 4'b0100; req0 = req4;
    tick();
    tick();
    check("mid owner", 32'(own4), 32'd2);
    do_reset();
    check("mid post-reset owner", 32'(own4), 32'd3);
    req4 = 4'b0101; req0 = req4;
    tick();
    check("mid m0 wins", 32'(own4), 32'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      tick();
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req4[b] = ~req4[b];
        if ($urandom_range(7) == 0) req0[b] = ~req0[b];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
